// File: rtl/servo_pkg.sv
// Shared types and timing helpers for the servo ramp / PWM slice.
package servo_pkg;

  typedef enum logic {IDLE, MOVE} state_t;

  localparam int CENTER = 128;

  function automatic int centerOf(input int posW);
    return 1 << (posW - 1);
  endfunction

  function automatic int frameCycles(input int clkHz, input int pwmHz);
    return clkHz / pwmHz;
  endfunction

  // 64-bit intermediate: microseconds times a 100 MHz clock overflows 32 bits
  function automatic int usToCycles(input int us, input int clkHz);
    longint prod;
    prod = longint'(us) * longint'(clkHz);
    return int'(prod / 64'd1_000_000);
  endfunction

  function automatic int scaleOf(input int minCyc, input int maxCyc, input int posW);
    return (maxCyc - minCyc) / ((1 << posW) - 1);
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// 50 Hz servo frame generator: frame counter, frame-boundary width latch and
// pulse compare with a registered output.
module servo_pwm_gen #(
  parameter int FRAME_CYC = 2_000_000,
  parameter int MIN_CYC   = 100_000,
  parameter int SCALE     = 392,
  parameter int POS_W     = 8,
  parameter int RST_WIDTH = 150_176
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [POS_W-1:0] pos_i,
  output logic             frame_start_o,
  output logic             pwm_o
);

  localparam int CNT_W = $clog2(FRAME_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_d;
  logic             frame_start_q;
  logic             pwm_q;

  always_comb begin
    width_d = CNT_W'(MIN_CYC) + CNT_W'(pos_i) * CNT_W'(SCALE);
  end

  // Width only reloads on the last count so a pulse is never cut or stretched mid-frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      width_q       <= CNT_W'(RST_WIDTH);
      frame_start_q <= 1'b0;
      pwm_q         <= 1'b0;
    end else begin
      frame_start_q <= (cnt_q == '0);
      pwm_q         <= (cnt_q < width_q);
      if (cnt_q == LAST_CNT) begin
        cnt_q   <= '0;
        width_q <= width_d;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign frame_start_o = frame_start_q;
  assign pwm_o         = pwm_q;

endmodule

// File: rtl/servo_ramp_pwm.sv
// Servo position ramp: latches targets, steps toward them on each tick and drives the PWM.
// Optional SERVO_LIMIT_EN clamps accepted targets to [LIM_LO, LIM_HI] and pulses limit_hit.
module servo_ramp_pwm
  import servo_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int PWM_HZ = 50,
  parameter int MIN_US = 1000,
  parameter int MAX_US = 2000,
  parameter int POS_W  = 8,
  parameter int STEP   = 4
`ifdef SERVO_LIMIT_EN
  ,
  parameter int LIM_LO = 20,
  parameter int LIM_HI = 235
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [POS_W-1:0] target,
  input  logic             target_valid,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             frame_start,
  output logic             limit_hit,
  output logic             pwm_out
);

  localparam int FRAME_CYC = frameCycles(CLK_HZ, PWM_HZ);
  localparam int MIN_CYC   = usToCycles(MIN_US, CLK_HZ);
  localparam int MAX_CYC   = usToCycles(MAX_US, CLK_HZ);
  localparam int SCALE     = scaleOf(MIN_CYC, MAX_CYC, POS_W);
  localparam int CENTER_I  = centerOf(POS_W);
  localparam logic [POS_W-1:0] CENTER_POS = POS_W'(CENTER_I);
  localparam logic [POS_W:0]   POS_MAX    = (POS_W+1)'((1 << POS_W) - 1);
  localparam logic [POS_W:0]   STEP_W     = (POS_W+1)'(STEP);

  state_t                 state_q;
  logic [POS_W-1:0]       pos_q;
  logic [POS_W-1:0]       pos_d;
  logic [POS_W-1:0]       tgt_q;
  logic                   busy_q;
  logic                   limit_q;
  logic [POS_W-1:0]       tgtClamped;
  logic                   clampHit;
  logic signed [POS_W:0]  diff;
  logic [POS_W:0]         mag;
  logic [POS_W:0]         stepAmt;
  logic [POS_W:0]         sumUp;

  always_comb begin
    tgtClamped = target;
    clampHit   = 1'b0;
`ifdef SERVO_LIMIT_EN
    if (target < POS_W'(LIM_LO)) begin
      tgtClamped = POS_W'(LIM_LO);
      clampHit   = 1'b1;
    end else if (target > POS_W'(LIM_HI)) begin
      tgtClamped = POS_W'(LIM_HI);
      clampHit   = 1'b1;
    end
`endif
  end

  // One extra bit keeps the signed difference and the upward sum from wrapping
  always_comb begin
    diff    = $signed({1'b0, tgt_q}) - $signed({1'b0, pos_q});
    mag     = diff[POS_W] ? $unsigned(-diff) : $unsigned(diff);
    stepAmt = (mag > STEP_W) ? STEP_W : mag;
    sumUp   = {1'b0, pos_q} + stepAmt;
    pos_d   = pos_q;
    if (!diff[POS_W]) begin
      pos_d = (sumUp > POS_MAX) ? POS_MAX[POS_W-1:0] : sumUp[POS_W-1:0];
    end else if ({1'b0, pos_q} < stepAmt) begin
      pos_d = '0;
    end else begin
      pos_d = pos_q - stepAmt[POS_W-1:0];
    end
  end

  // A step in the same cycle as a new target still uses the previously latched target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= CENTER_POS;
      tgt_q   <= CENTER_POS;
      busy_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      limit_q <= target_valid & clampHit;
      if (target_valid) begin
        tgt_q <= tgtClamped;
      end
      case (state_q)
        IDLE: begin
          if (tgt_q != pos_q) begin
            state_q <= MOVE;
            busy_q  <= 1'b1;
          end
        end
        MOVE: begin
          if (pos_q == tgt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            pos_q <= pos_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  servo_pwm_gen #(
    .FRAME_CYC(FRAME_CYC),
    .MIN_CYC  (MIN_CYC),
    .SCALE    (SCALE),
    .POS_W    (POS_W),
    .RST_WIDTH(MIN_CYC + CENTER_I * SCALE)
  ) uPwmGen (
    .clk_i        (clk),
    .rst_i        (rst),
    .pos_i        (pos_q),
    .frame_start_o(frame_start),
    .pwm_o        (pwm_out)
  );

  assign pos       = pos_q;
  assign busy      = busy_q;
  assign limit_hit = limit_q;

endmodule
